serial_tx_buffer: RTL
=====================

Name: serial_tx_buffer

Overview:
- Consumes the IO unit's serial write stream (serialWE / serialWriteDataOut) and buffers the bytes in a small FIFO.
- Serialises each byte as an 8N1 UART frame on a single output pin.
- Sits directly downstream of the IO unit, at the chip-top serial port.
- Decouples single-cycle store commits from slow bit-rate transmission.

Parameters:
- SERIAL_DATA_WIDTH, 8, width of one serial character (must equal the IO unit's serial data path width).
- FIFO_DEPTH, 16, number of buffered characters; power of two, >= 2.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- serialWE  in  1  write strobe from the IO unit; one character per cycle while high.
- serialWriteData  in  SERIAL_DATA_WIDTH  character to enqueue; sampled when serialWE=1.
- serialTx  out  1  UART line; idle high.
- txBusy  out  1  high while a frame is in flight or the FIFO is non-empty.
- fifoFull  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (asynchronous, any state):
  - FIFO pointers and count cleared; FSM to IDLE; bit and baud counters cleared.
  - serialTx=1, txBusy=0, fifoFull=0, overflow=0.
  - A frame in progress is abandoned; the line returns high immediately and no partial frame resumes.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
  - Write is accepted if serialWE=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - A write that is not accepted is dropped and sets overflow=1 on that edge; overflow stays set until rst.
  - Simultaneous push and pop leaves count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if count!=0 at the edge, pop the head into a shift register, drive serialTx<=0, clear the baud counter, go to START. Otherwise serialTx=1.
  - START: hold 0 for CLKS_PER_BIT cycles, then drive bit 0 (LSB first) and go to DATA with bitIdx=0.
  - DATA: each bit is held CLKS_PER_BIT cycles. After bitIdx=SERIAL_DATA_WIDTH-1 completes, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles, then go to IDLE. IDLE may immediately pop the next character on the same edge it is entered, so back-to-back frames have no extra idle gap.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the terminal count; the state/bit advance occurs on the wrap.
- Frame length: exactly (SERIAL_DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- Latency: with the FIFO empty and the FSM in IDLE, a write captured at edge N causes serialTx to fall at edge N+1.
- Outputs are registered. serialTx changes only on clock edges.
- txBusy = (state!=IDLE) || (count!=0).

Optional Feature:
- Macro RSD_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles, and the frame becomes (SERIAL_DATA_WIDTH+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 framing as above.

Test Plan:
- Reset values: with CLKS_PER_BIT=4, assert rst mid-frame -> serialTx=1, txBusy=0, overflow=0 asynchronously, before the next clk edge.
- Single byte: write 0xA5 at edge N -> serialTx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles. txBusy falls after 40 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; the second frame's start bit immediately follows the first frame's stop bit.
- Overflow: FIFO_DEPTH=4, FSM busy, write 6 bytes in 6 cycles (the first is popped at once) -> bytes 1..5 fill the FIFO except one dropped. fifoFull=1, overflow=1 and stays 1. Exactly 5 frames appear, in write order.
- Full plus simultaneous pop: FIFO full, write on the same cycle the FSM pops -> write accepted, count stays FIFO_DEPTH, overflow unchanged.
- Parity (RSD_SERIAL_TX_PARITY_EN): write 0x07 -> parity bit 1 after the data bits. Frame length 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/serial_tx_buffer.sv
// serial_tx_buffer: buffers characters from the IO unit's serial write stream
// in a small circular FIFO and serialises each one as a UART frame
// (start bit, LSB-first data bits, stop bit) on a single idle-high pin.
//
// Optional feature (macro RSD_SERIAL_TX_PARITY_EN): inserts an even-parity
// bit between the last data bit and the stop bit.
//
// Ports:
//   clk              system clock
//   rst              asynchronous, active-high reset
//   serialWE         write strobe, one character per cycle while high
//   serialWriteData  character to enqueue, sampled when serialWE=1
//   serialTx         UART line, idle high (registered)
//   txBusy           frame in flight or FIFO non-empty (registered)
//   fifoFull         FIFO holds FIFO_DEPTH entries (registered)
//   overflow         sticky, set when a write is dropped (registered)
module serial_tx_buffer #(
    parameter int unsigned SERIAL_DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT      = 868
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         serialWE,
    input  logic [SERIAL_DATA_WIDTH-1:0] serialWriteData,
    output logic                         serialTx,
    output logic                         txBusy,
    output logic                         fifoFull,
    output logic                         overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = (SERIAL_DATA_WIDTH > 1) ? $clog2(SERIAL_DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(SERIAL_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_e;

    txState_e state, stateNext;

    logic [SERIAL_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wrPtr, rdPtr;
    logic [CNT_W-1:0]             count, countNext;
    logic [BAUD_W-1:0]            baudCnt, baudNext;
    logic [IDX_W-1:0]             bitIdx, bitIdxNext;
    logic [SERIAL_DATA_WIDTH-1:0] shiftReg, shiftNext;
    logic                         serialTxNext;
    logic                         baudWrap;
    logic                         pop, push;
`ifdef RSD_SERIAL_TX_PARITY_EN
    logic                         parityBit, parityNext;
`endif

    assign baudWrap = (baudCnt == BAUD_LAST);

    // Next-state / line logic; a STOP wrap may pop directly so frames abut.
    always_comb begin
        stateNext    = state;
        serialTxNext = serialTx;
        baudNext     = baudCnt;
        bitIdxNext   = bitIdx;
        shiftNext    = shiftReg;
        pop          = 1'b0;
`ifdef RSD_SERIAL_TX_PARITY_EN
        parityNext   = parityBit;
`endif

        if (state != IDLE) begin
            baudNext = baudWrap ? '0 : baudCnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                serialTxNext = 1'b1;
                if (count != '0) begin
                    pop          = 1'b1;
                    shiftNext    = mem[rdPtr];
                    serialTxNext = 1'b0;
                    baudNext     = '0;
                    stateNext    = START;
`ifdef RSD_SERIAL_TX_PARITY_EN
                    parityNext   = ^mem[rdPtr];
`endif
                end
            end
            START: begin
                if (baudWrap) begin
                    serialTxNext = shiftReg[0];
                    shiftNext    = shiftReg >> 1;
                    bitIdxNext   = '0;
                    stateNext    = DATA;
                end
            end
            DATA: begin
                if (baudWrap) begin
                    if (bitIdx == IDX_LAST) begin
`ifdef RSD_SERIAL_TX_PARITY_EN
                        serialTxNext = parityBit;
                        stateNext    = PARITY;
`else
                        serialTxNext = 1'b1;
                        stateNext    = STOP;
`endif
                    end else begin
                        serialTxNext = shiftReg[0];
                        shiftNext    = shiftReg >> 1;
                        bitIdxNext   = bitIdx + IDX_W'(1);
                    end
                end
            end
`ifdef RSD_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baudWrap) begin
                    serialTxNext = 1'b1;
                    stateNext    = STOP;
                end
            end
`endif
            STOP: begin
                if (baudWrap) begin
                    if (count != '0) begin
                        pop          = 1'b1;
                        shiftNext    = mem[rdPtr];
                        serialTxNext = 1'b0;
                        stateNext    = START;
`ifdef RSD_SERIAL_TX_PARITY_EN
                        parityNext   = ^mem[rdPtr];
`endif
                    end else begin
                        serialTxNext = 1'b1;
                        stateNext    = IDLE;
                    end
                end
            end
            default: begin
                serialTxNext = 1'b1;
                stateNext    = IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a write when a pop frees a slot on the same edge.
    assign push      = serialWE && ((count != COUNT_FULL) || pop);
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= serialWriteData;
        end
    end

    // State, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            serialTx  <= 1'b1;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            txBusy    <= 1'b0;
            fifoFull  <= 1'b0;
            overflow  <= 1'b0;
`ifdef RSD_SERIAL_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            serialTx  <= serialTxNext;
            baudCnt   <= baudNext;
            bitIdx    <= bitIdxNext;
            shiftReg  <= shiftNext;
            wrPtr     <= wrPtr + PTR_W'(push);
            rdPtr     <= rdPtr + PTR_W'(pop);
            count     <= countNext;
            txBusy    <= (stateNext != IDLE) || (countNext != '0);
            fifoFull  <= (countNext == COUNT_FULL);
            overflow  <= overflow | (serialWE & ~push);
`ifdef RSD_SERIAL_TX_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

endmodule
